// File: rtl/harris_corner_detector.sv
// Streaming Harris corner response over a raster RGB stream, one signed 18-bit result per pixel.
// Latency: 6 enabled edges, counted from the edge that samples the pixel WIDTH+2 after the centre.
// Backpressure: none; every register, counter and line-buffer write holds while clk_en=0.
//
// Ports: clk / reset (async, active-high), clk_en (active-video qualifier),
//        VGA_R/G/B (8-bit colour), threshold (signed suppression floor),
//        harris_feature (registered signed response, zero on borders and below threshold).
module harris_corner_detector #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_en,
  input  logic [7:0]         VGA_R,
  input  logic [7:0]         VGA_G,
  input  logic [7:0]         VGA_B,
  input  logic signed [17:0] threshold,
  output logic signed [17:0] harris_feature
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
  // The sample at (x, y) completes the tensor for centre (x-2, y-1); these bounds
  // translate the centre border rule into sample coordinates.
  localparam logic [XW-1:0] X_MIN  = XW'(4);
  localparam logic [YW-1:0] Y_MIN  = YW'(3);
  localparam logic [YW-1:0] Y_MAX  = YW'(HEIGHT - 2);

  logic [XW-1:0] x;
  logic [YW-1:0] y;

  // Grayscale
  logic [9:0] gsum;
  logic [7:0] gray;
  assign gsum = {2'b0, VGA_R} + {1'b0, VGA_G, 1'b0} + {2'b0, VGA_B};
  assign gray = 8'(gsum >> 2);

  // Line buffers: lb1 holds the previous line, lb2 the one before; contents never reset.
  logic [7:0] lb1 [0:WIDTH-1];
  logic [7:0] lb2 [0:WIDTH-1];
  logic [7:0] lb1_rd, lb2_rd;
  assign lb1_rd = lb1[x];
  assign lb2_rd = lb2[x];

  always_ff @(posedge clk) begin
    if (clk_en && !reset) begin
      lb1[x] <= gray;
      lb2[x] <= lb1_rd;
    end
  end

  // win[row][col]: row 0 = top, col 2 = newest column
  logic [2:0][2:0][7:0] win;

  function automatic logic signed [10:0] wsum(input logic [7:0] a, input logic [7:0] b,
                                              input logic [7:0] c);
    return $signed({3'b0, a} + {2'b0, b, 1'b0} + {3'b0, c});
  endfunction

  logic signed [10:0] ix_full, iy_full;
  assign ix_full = wsum(win[0][2], win[1][2], win[2][2]) - wsum(win[0][0], win[1][0], win[2][0]);
  assign iy_full = wsum(win[2][0], win[2][1], win[2][2]) - wsum(win[0][0], win[0][1], win[0][2]);

  logic signed [10:0] ix_r, iy_r;
  logic [16:0]        a_r, a_d1, a_d2, b_r, b_d1, b_d2;
  logic [17:0]        c_r, c_d1, c_d2;
  logic [18:0]        sa_r, sb_r;
  logic signed [18:0] sc_r;
  logic signed [47:0] det_r;
  logic [19:0]        tr_r;
  logic [4:0]         vld_pipe;

  logic signed [47:0] sa_w, sb_w, sc_w;
  assign sa_w = $signed({29'b0, sa_r});
  assign sb_w = $signed({29'b0, sb_r});
  assign sc_w = $signed({{29{sc_r[18]}}, sc_r});

  // Output stage: floor shift, then saturate, then suppress
  logic [39:0]        tr_sq;
  logic signed [47:0] resp_full;
  logic signed [17:0] resp_sat;
  always_comb begin
    tr_sq     = {20'b0, tr_r} * {20'b0, tr_r};
    resp_full = (det_r - $signed({8'b0, tr_sq >> 4})) >>> 16;
    resp_sat  = resp_full[17:0];
    if (resp_full > 48'sd131071)
      resp_sat = 18'sh1FFFF;
    else if (resp_full < -48'sd131072)
      resp_sat = 18'sh20000;
  end

  logic samp_vld;
  assign samp_vld = (x >= X_MIN) && (y >= Y_MIN) && (y <= Y_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x              <= '0;
      y              <= '0;
      win            <= '0;
      ix_r           <= '0;
      iy_r           <= '0;
      a_r            <= '0;
      a_d1           <= '0;
      a_d2           <= '0;
      b_r            <= '0;
      b_d1           <= '0;
      b_d2           <= '0;
      c_r            <= '0;
      c_d1           <= '0;
      c_d2           <= '0;
      sa_r           <= '0;
      sb_r           <= '0;
      sc_r           <= '0;
      det_r          <= '0;
      tr_r           <= '0;
      vld_pipe       <= '0;
      harris_feature <= '0;
    end else if (clk_en) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
      // stage 1: window shift
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb2_rd;
      win[1][2] <= lb1_rd;
      win[2][2] <= gray;
      // stage 2: Sobel, scaled to +/-255
      ix_r <= ix_full >>> 2;
      iy_r <= iy_full >>> 2;
      // stage 3: products; the delayed copies give the p and p-1 terms for stage 4
      a_r  <= {{6{ix_r[10]}}, ix_r} * {{6{ix_r[10]}}, ix_r};
      b_r  <= {{6{iy_r[10]}}, iy_r} * {{6{iy_r[10]}}, iy_r};
      c_r  <= {{7{ix_r[10]}}, ix_r} * {{7{iy_r[10]}}, iy_r};
      a_d1 <= a_r;
      a_d2 <= a_d1;
      b_d1 <= b_r;
      b_d2 <= b_d1;
      c_d1 <= c_r;
      c_d2 <= c_d1;
      // stage 4: horizontal sums
      sa_r <= {2'b0, a_r} + {2'b0, a_d1} + {2'b0, a_d2};
      sb_r <= {2'b0, b_r} + {2'b0, b_d1} + {2'b0, b_d2};
      sc_r <= $signed({c_r[17], c_r} + {c_d1[17], c_d1} + {c_d2[17], c_d2});
      // stage 5: determinant and trace
      det_r <= sa_w * sb_w - sc_w * sc_w;
      tr_r  <= {1'b0, sa_r} + {1'b0, sb_r};
      // stage 6: output
      vld_pipe <= {vld_pipe[3:0], samp_vld};
      if (vld_pipe[4] && resp_sat >= threshold)
        harris_feature <= resp_sat;
      else
        harris_feature <= '0;
    end
  end

endmodule

// File: tb/tb_harris_corner_detector.sv
module tb_harris_corner_detector;

  localparam int W  = 128;
  localparam int H  = 10;
  localparam int FR = W * H;

  logic               clk = 1'b0;
  logic               reset;
  logic               clk_en;
  logic [7:0]         vga_r, vga_g, vga_b;
  logic signed [17:0] threshold;
  logic signed [17:0] harris_feature;

  always #5 clk = ~clk;

  harris_corner_detector #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk           (clk),
    .reset         (reset),
    .clk_en        (clk_en),
    .VGA_R         (vga_r),
    .VGA_G         (vga_g),
    .VGA_B         (vga_b),
    .threshold     (threshold),
    .harris_feature(harris_feature)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // gray image of the stream since the last reset, indexed by stream index
  int gmem   [0:65535];
  int dut_at [0:65535];
  int s      = 0;
  int exp_q  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      if (n_bad <= 25)
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint fdiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  function automatic int pix(input int base, input int px, input int py);
    return gmem[base + py * W + px];
  endfunction

  // Harris response for centre g straight from the definition
  function automatic int ref_resp(input int g, input int thr);
    longint sa, sb, sc, det, tr, r, gx, gy;
    int base, l, cx, cy, px, wt;
    if (g < 0) return 0;
    base = (g / FR) * FR;
    l    = g % FR;
    cx   = l % W;
    cy   = l / W;
    if (cx < 2 || cx > W - 3 || cy < 2 || cy > H - 3) return 0;
    sa = 0; sb = 0; sc = 0;
    for (int dx = -1; dx <= 1; dx++) begin
      px = cx + dx;
      gx = 0; gy = 0;
      for (int k = -1; k <= 1; k++) begin
        wt = (k == 0) ? 2 : 1;
        gx += wt * (pix(base, px + 1, cy + k) - pix(base, px - 1, cy + k));
        gy += wt * (pix(base, px + k, cy + 1) - pix(base, px + k, cy - 1));
      end
      gx = fdiv(gx, 4);
      gy = fdiv(gy, 4);
      sa += gx * gx;
      sb += gy * gy;
      sc += gx * gy;
    end
    det = sa * sb - sc * sc;
    tr  = sa + sb;
    r   = fdiv(det - (tr * tr) / 16, 65536);
    if (r > 131071)  r = 131071;
    if (r < -131072) r = -131072;
    return (r >= thr) ? int'(r) : 0;
  endfunction

  // Compare process: model update at the edge, DUT sampled 1 time unit later
  always begin : mon
    int  g;
    bit  rec;
    int  rec_g;
    @(posedge clk);
    rec = 0;
    if (reset) begin
      s     = 0;
      exp_q = 0;
    end else if (clk_en) begin
      gmem[s] = (int'(vga_r) + 2 * int'(vga_g) + int'(vga_b)) / 4;
      s++;
      g     = s - W - 8;
      exp_q = ref_resp(g, int'(threshold));
      if (g >= 0) begin
        rec   = 1;
        rec_g = g;
      end
    end
    #1;
    check("stream", int'(harris_feature), exp_q);
    if (rec) dut_at[rec_g] = int'(harris_feature);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      clk_en = 1'b0;
      vga_r  = 8'($urandom);
      vga_g  = 8'($urandom);
      vga_b  = 8'($urandom);
    end
  endtask

  // mode: 0 black, 1 uniform 128, 2 vertical step at x=100/101, 3 white 3x3 square,
  //       4 full-range random colour, 5 low-amplitude random gray
  task automatic send_frame(input int mode, input int thr, input int npix, input int gap_at);
    for (int idx = 0; idx < npix; idx++) begin
      int px, py, lv;
      px = idx % W;
      py = idx / W;
      if (idx == gap_at) idle(50);
      if (mode >= 4 && $urandom_range(0, 7) == 0) idle(1);
      @(negedge clk);
      clk_en = 1'b1;
      if (idx == 0) threshold = 18'(thr);
      case (mode)
        1:       lv = 128;
        2:       lv = (px <= 100) ? 0 : 255;
        3:       lv = (px >= 50 && px <= 52 && py >= 4 && py <= 6) ? 255 : 0;
        5:       lv = int'($urandom_range(0, 31));
        default: lv = 0;
      endcase
      if (mode == 4) begin
        vga_r = 8'($urandom);
        vga_g = 8'($urandom);
        vga_b = 8'($urandom);
      end else begin
        vga_r = 8'(lv);
        vga_g = 8'(lv);
        vga_b = 8'(lv);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    clk_en = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_hold", int'(harris_feature), 0);
    reset = 1'b0;
  endtask

  function automatic int cidx(input int f, input int cx, input int cy);
    return f * FR + cy * W + cx;
  endfunction

  initial begin
    reset     = 1'b1;
    clk_en    = 1'b0;
    vga_r     = '0;
    vga_g     = '0;
    vga_b     = '0;
    threshold = '0;
    repeat (2) @(negedge clk);
    check("reset_out", int'(harris_feature), 0);
    reset = 1'b0;

    send_frame(0, 0, FR, -1);                                      // frame 0
    send_frame(1, 0, FR, -1);                                      // frame 1
    send_frame(2, -131072, FR, -1);                                // frame 2
    send_frame(2, 0, FR, -1);                                      // frame 3
    send_frame(3, 0, FR, -1);                                      // frame 4
    send_frame(4, int'($urandom_range(0, 262143)) - 131072, FR, 3 * W + 60);  // frame 5
    send_frame(5, int'($urandom_range(0, 2000)) - 1000, FR, -1);   // frame 6

    check("black_interior",   dut_at[cidx(0, 60, 5)], 0);
    check("uniform_interior", dut_at[cidx(1, 60, 5)], 0);
    check("uniform_edge_col", dut_at[cidx(1, 2, 2)], 0);
    check("step_x100",        dut_at[cidx(2, 100, 5)], -16130);
    check("step_x101",        dut_at[cidx(2, 101, 4)], -16130);
    check("step_x97",         dut_at[cidx(2, 97, 5)], 0);
    check("step_x104",        dut_at[cidx(2, 104, 5)], 0);
    check("step_border_y1",   dut_at[cidx(2, 100, 1)], 0);
    check("step_thr0",        dut_at[cidx(3, 100, 5)], 0);
    check("square_corner",    dut_at[cidx(4, 50, 4)], 51148);
    check("square_bg",        dut_at[cidx(4, 20, 5)], 0);
    check("model_step",       ref_resp(cidx(2, 101, 6), -131072), -16130);
    check("model_square",     ref_resp(cidx(4, 50, 4), 0), 51148);

    send_frame(4, 0, 500, -1);
    do_reset();
    send_frame(5, int'($urandom_range(0, 600)) - 300, FR, 5 * W + 17);
    send_frame(0, 0, FR, -1);
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
